// File: rtl/mem_arbiter.sv
// Main-memory arbiter: 8-word block fills for I and D, single-word write-through stores for D.
// Define ARB_RR_EN for round-robin I/D priority; the default build gives D fixed priority over I.
module mem_arbiter #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16,
    parameter int WIDX_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_wdata,
    output logic              i_grant,
    output logic              d_grant,
    output logic              fill_valid,
    output logic [15:0]       fill_data,
    output logic [WIDX_W-1:0] fill_word,
    output logic              fill_done,
    output logic              wr_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy
);
    localparam int OFF_W = WIDX_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2} state_e;

    state_e                   state_q;
    logic [ADDR_W-OFF_W-1:0]  blk_q;
    logic [WIDX_W:0]          issue_cnt_q;
    logic [WIDX_W-1:0]        recv_cnt_q;
    logic                     i_grant_q;
    logic                     d_grant_q;
    logic                     mem_en_q;
    logic                     mem_wr_q;
    logic                     wr_done_q;
    logic [ADDR_W-1:0]        mem_addr_q;
    logic [15:0]              mem_wdata_q;
    logic                     pick_d;
    logic                     pick_i;
    logic                     fill_last;
    logic                     unused_addr_bits;
`ifdef ARB_RR_EN
    logic                     prio_d_q;
`endif

    // Low address bits select a word inside the block and never reach the latched block base.
    assign unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

    // Arbitration decision for the IDLE sampling edge.
    always_comb begin
        pick_d = 1'b0;
        pick_i = 1'b0;
`ifdef ARB_RR_EN
        if (d_req && (!i_req || prio_d_q)) begin
            pick_d = 1'b1;
        end else if (i_req) begin
            pick_i = 1'b1;
        end else begin
            pick_d = 1'b0;
        end
`else
        if (d_req) begin
            pick_d = 1'b1;
        end else if (i_req) begin
            pick_i = 1'b1;
        end else begin
            pick_d = 1'b0;
        end
`endif
    end

    // Returned data is passed straight through; it is forced to zero whenever no fill word is valid.
    assign fill_valid = (state_q == FILL) && mem_rvalid;
    assign fill_data  = fill_valid ? mem_rdata : 16'h0000;
    assign fill_word  = recv_cnt_q;
    assign fill_last  = fill_valid && (recv_cnt_q == WIDX_W'(BLOCK_WORDS - 1));
    assign fill_done  = fill_last;
    assign i_grant    = i_grant_q;
    assign d_grant    = d_grant_q;
    assign wr_done    = wr_done_q;
    assign mem_en     = mem_en_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = (state_q != IDLE);

    // Transaction FSM with registered grant and memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            blk_q       <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            i_grant_q   <= 1'b0;
            d_grant_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            wr_done_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 16'h0000;
`ifdef ARB_RR_EN
            prio_d_q    <= 1'b1;
`endif
        end else if (state_q == IDLE) begin
            if (pick_d) begin
                d_grant_q   <= 1'b1;
                mem_en_q    <= 1'b1;
                mem_wdata_q <= d_wdata;
                blk_q       <= d_addr[ADDR_W-1:OFF_W];
                if (d_wr) begin
                    state_q    <= WRITE;
                    mem_wr_q   <= 1'b1;
                    wr_done_q  <= 1'b1;
                    mem_addr_q <= {d_addr[ADDR_W-1:1], 1'b0};
                end else begin
                    state_q     <= FILL;
                    mem_addr_q  <= {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    issue_cnt_q <= OFF_W'(1);
                end
`ifdef ARB_RR_EN
                prio_d_q <= 1'b0;
`endif
            end else if (pick_i) begin
                state_q     <= FILL;
                i_grant_q   <= 1'b1;
                mem_en_q    <= 1'b1;
                blk_q       <= i_addr[ADDR_W-1:OFF_W];
                mem_addr_q  <= {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                issue_cnt_q <= OFF_W'(1);
`ifdef ARB_RR_EN
                prio_d_q <= 1'b1;
`endif
            end else begin
                state_q <= IDLE;
            end
        end else if ((state_q == FILL) && !fill_last) begin
            // Word offset is OR-ed into the block base, so the fill can never carry out of the block.
            if (!issue_cnt_q[WIDX_W]) begin
                mem_addr_q  <= {blk_q, issue_cnt_q[WIDX_W-1:0], 1'b0};
                issue_cnt_q <= issue_cnt_q + OFF_W'(1);
            end else begin
                mem_en_q   <= 1'b0;
                mem_addr_q <= '0;
            end
            if (mem_rvalid) begin
                recv_cnt_q <= recv_cnt_q + WIDX_W'(1);
            end else begin
                recv_cnt_q <= recv_cnt_q;
            end
        end else begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            i_grant_q   <= 1'b0;
            d_grant_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            wr_done_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 16'h0000;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// cycle-offset reference model and a latency-configurable pipelined memory model.
module tb_mem_arbiter;
    localparam int BW = 8;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk, rst_n;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_grant, d_grant, fill_valid, fill_done, wr_done;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        mem_en, mem_wr, mem_rvalid, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_grant(i_grant), .d_grant(d_grant),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_word(fill_word), .fill_done(fill_done),
        .wr_done(wr_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: owner 0 = none, 1 = I fill, 2 = D fill, 3 = D write.
    int          m_own, m_start, m_rx;
    bit          m_d_first;
    logic [15:0] m_base, m_waddr, m_wdata;

    // Memory model and stimulus knobs.
    int          due_q[$];
    logic [15:0] dat_q[$];
    int          lat;
    logic [15:0] salt;
    bit          stray_en, rand_mode;
    int          last_i_done, n_done, t0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_rx = 0; m_start = 0; m_d_first = 1'b1;
        due_q.delete(); dat_q.delete();
    endtask

    task automatic check_outputs();
        bit          fill, exp_en, exp_fv;
        int          off;
        logic [15:0] e_addr, e_data;
        fill   = (m_own == 1) || (m_own == 2);
        off    = cyc - m_start;
        exp_fv = fill && (mem_rvalid === 1'b1);
        exp_en = (fill && off < BW) || (m_own == 3);
        e_addr = (m_own == 3) ? m_waddr : (m_base + 16'(2 * off));
        e_data = exp_fv ? (salt + 16'(m_rx)) : 16'h0000;
        check_val("busy", busy, m_own != 0);
        check_val("i_grant", i_grant, m_own == 1);
        check_val("d_grant", d_grant, m_own >= 2);
        check_val("mem_en", mem_en, exp_en);
        check_val("mem_wr", mem_wr, m_own == 3);
        if (exp_en) check_val("mem_addr", mem_addr, e_addr);
        if (m_own == 3) check_val("mem_wdata", mem_wdata, m_wdata);
        check_val("wr_done", wr_done, m_own == 3);
        check_val("fill_valid", fill_valid, exp_fv);
        check_val("fill_data", fill_data, e_data);
        if (exp_fv) check_val("fill_word", fill_word, m_rx);
        check_val("fill_done", fill_done, exp_fv && m_rx == BW - 1);
    endtask

    task automatic model_edge();
        bit done;
        done = ((m_own == 1) || (m_own == 2)) && mem_rvalid && m_rx == BW - 1;
        if (!rst_n) begin
            model_reset();
        end else if (m_own == 3 || done) begin
            m_own = 0; m_rx = 0;
        end else if (m_own != 0) begin
            if (mem_rvalid) m_rx++;
        end else if (d_req && (!i_req || m_d_first)) begin
            m_own   = d_wr ? 3 : 2;
            m_start = cyc + 1; m_rx = 0;
            m_base  = d_addr & 16'hFFF0;
            m_waddr = d_addr & 16'hFFFE;
            m_wdata = d_wdata;
            if (RR) m_d_first = 1'b0;
        end else if (i_req) begin
            m_own   = 1;
            m_start = cyc + 1; m_rx = 0;
            m_base  = i_addr & 16'hFFF0;
            if (RR) m_d_first = 1'b1;
        end
    endtask

    task automatic drive_reqs(input bit done_exp);
        bit i_done, d_done;
        i_done = done_exp && m_own == 1;
        d_done = (done_exp && m_own == 2) || m_own == 3;
        if (!rand_mode) begin
            if (i_done) i_req = 1'b0;
            if (d_done) d_req = 1'b0;
        end else begin
            if (i_req && i_done) begin
                i_req = 1'($urandom_range(1)); i_addr = 16'($urandom);
            end else if (i_req && m_own == 1 && $urandom_range(15) == 0) begin
                i_req = 1'b0;
            end else if (!i_req && m_own != 1 && $urandom_range(3) == 0) begin
                i_req = 1'b1; i_addr = 16'($urandom);
            end
            if (d_req && d_done) begin
                d_req = 1'($urandom_range(1)); d_addr = 16'($urandom);
                d_wr = 1'($urandom_range(1)); d_wdata = 16'($urandom);
            end else if (d_req && m_own >= 2 && $urandom_range(15) == 0) begin
                d_req = 1'b0;
            end else if (!d_req && m_own < 2 && $urandom_range(3) == 0) begin
                d_req = 1'b1; d_addr = 16'($urandom);
                d_wr = 1'($urandom_range(1)); d_wdata = 16'($urandom);
            end
        end
    endtask

    // One clock cycle: check at the falling edge, drive, advance the model across the rising edge.
    task automatic step();
        bit done_exp;
        if (rand_mode && m_own == 0 && due_q.size() == 0 && $urandom_range(7) == 0) begin
            lat  = $urandom_range(6, 1);
            salt = 16'($urandom);
        end
        check_outputs();
        done_exp = ((m_own == 1) || (m_own == 2)) && mem_rvalid && m_rx == BW - 1;
        if (fill_done === 1'b1) n_done++;
        if (fill_done === 1'b1 && i_grant === 1'b1) last_i_done = cyc;
        drive_reqs(done_exp);
        if (mem_en === 1'b1 && mem_wr === 1'b0) begin
            due_q.push_back(cyc + lat);
            dat_q.push_back(salt + 16'((mem_addr >> 1) & 16'h0007));
        end
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = dat_q[0];
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
        end else if (stray_en && m_own != 1 && m_own != 2 && $urandom_range(3) == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'($urandom);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
        mem_rvalid = 1'b0; mem_rdata = 16'h0000;
        lat = 4; salt = 16'hA000; stray_en = 1'b0; rand_mode = 1'b0;
        last_i_done = 0; n_done = 0;
        model_reset();
        @(negedge clk);
        run(2);
        rst_n = 1'b1;
        run(2);

        // I fill with latency 4: done lands 12 cycles after the request is sampled.
        i_req = 1'b1; i_addr = 16'h1236; t0 = cyc;
        run(16);
        check_val("i_fill_done_cycle", last_i_done - t0, 12);

        // D single-word write.
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h2001; d_wdata = 16'hBEEF;
        run(4);

        // Simultaneous requests; D was served last.
        i_req = 1'b1; i_addr = 16'h3000; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h4008;
        step();
        check_val("simul_first_owner", {i_grant, d_grant}, RR ? 2'b10 : 2'b01);
        run(30);

        // Top-of-memory fill must not carry out of the block; then stray rvalid while idle.
        salt = 16'h5A00;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'hFFFE;
        run(16);
        stray_en = 1'b1;
        run(10);

        // Requester drops its request mid-fill; the fill still completes.
        n_done = 0;
        i_req = 1'b1; i_addr = 16'h0520;
        run(3);
        i_req = 1'b0;
        run(14);
        check_val("drop_done_count", n_done, 1);

        // Asynchronous reset in the middle of a fill.
        stray_en = 1'b0;
        i_req = 1'b1; i_addr = 16'h7770;
        run(6);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_ctrl", {i_grant, d_grant, fill_valid, fill_done, wr_done, mem_en, mem_wr, busy}, 8'h00);
        check_val("rst_mem_addr", mem_addr, 16'h0000);
        check_val("rst_mem_wdata", mem_wdata, 16'h0000);
        check_val("rst_fill_data", fill_data, 16'h0000);
        check_val("rst_fill_word", fill_word, 3'd0);
        model_reset();
        i_req = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        run(2);
        rst_n = 1'b1;
        i_req = 1'b1; i_addr = 16'h0046;
        run(14);

        // Randomized traffic with varying memory latency and stray returns.
        rand_mode = 1'b1; stray_en = 1'b1;
        run(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
